// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - register bus between the MMU and the PS/2 host transmitter
interface ps2_host_tx_if;
  logic        sel;
  logic        we;
  logic        re;
  logic [31:0] din;
  logic [31:0] dout;
  logic        busy;

  modport master (output sel, output we, output re, output din, input dout, input busy);
  modport slave  (input sel, input we, input re, input din, output dout, output busy);
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic            clock,
  input  logic            clrn,
  ps2_host_tx_if.slave    bus,
  input  logic            ps2_clk_in,
  input  logic            ps2_dat_in,
  output logic            ps2_clk_oe,
  output logic            ps2_dat_oe
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [7:0]    byte_q;
  logic          parity_q;
  logic          done;
  logic          ack_err;
  logic          timeout_err;
  logic          busy_q;
  logic          clk_s1, clk_s2, clk_s3;
  logic          dat_s1, dat_s2;
  logic          fall;
  logic [9:0]    frame;
  logic          unused_din;

  assign unused_din = ^bus.din[31:8];

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_dat_in;
      dat_s2 <= dat_s1;
    end
  end

  assign fall  = clk_s3 & ~clk_s2;
  assign frame = {1'b1, parity_q, byte_q};

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      byte_q      <= '0;
      parity_q    <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
      busy_q      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_dat_oe  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sel && bus.re) begin
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
          end
          if (bus.sel && bus.we) begin
            byte_q      <= bus.din[7:0];
            parity_q    <= ~^bus.din[7:0];
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= '0;
            ps2_clk_oe  <= 1'b1;
            ps2_dat_oe  <= 1'b0;
            busy_q      <= 1'b1;
            state       <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt        <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b1;
            state      <= START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // The device owns the clock from here on; a silent device is abandoned.
          if (!fall && cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_dat_oe  <= 1'b0;
            busy_q      <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= fall ? '0 : cnt + 1'b1;
            case (state)
              START: if (fall) begin
                idx        <= '0;
                ps2_dat_oe <= ~frame[0];
                state      <= SHIFT;
              end
              SHIFT: if (fall) begin
                idx        <= idx + 4'd1;
                ps2_dat_oe <= ~frame[idx + 4'd1];
                if (idx == 4'd8) state <= ACK;
              end
              ACK: if (fall) begin
                ack_err <= dat_s2;
                state   <= WAIT_IDLE;
              end
              WAIT_IDLE: if (clk_s2 && dat_s2) begin
                done   <= 1'b1;
                busy_q <= 1'b0;
                cnt    <= '0;
                state  <= IDLE;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.dout = {16'h0000, byte_q, 4'h0, timeout_err, ack_err, done, busy_q};

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 200;

  logic clock = 1'b0;
  logic clrn  = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic ps2_clk_oe, ps2_dat_oe;
  logic ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_line = dev_dat & ~ps2_dat_oe;

  ps2_host_tx_if bus();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock      (clock),
    .clrn       (clrn),
    .bus        (bus),
    .ps2_clk_in (ps2_clk_line),
    .ps2_dat_in (ps2_dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int m_mode = 0;
  logic [31:0] m_dout = '0;
  logic [7:0]  m_byte = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic exp_frame_bit(input logic [7:0] b, input int i);
    int ones;
    ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(b[k]);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9) return (ones % 2) == 0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_status(input logic [7:0] b, input bit d, input bit ae, input bit te);
    return (32'(b) << 8) + (32'(d) << 1) + (32'(ae) << 2) + (32'(te) << 3);
  endfunction

  always @(negedge clock) begin
    if (m_mode == 1) begin
      chk("idle_busy", bus.busy, 0);
      chk("idle_clk_oe", ps2_clk_oe, 0);
      chk("idle_dat_oe", ps2_dat_oe, 0);
      chk("idle_dout", bus.dout, m_dout);
    end else if (m_mode == 2) begin
      chk("xfer_busy", bus.busy, 1);
      chk("xfer_byte", bus.dout[15:8], m_byte);
    end
  end

  task automatic bus_write(input logic [7:0] b);
    @(negedge clock);
    bus.din = {24'hA5A5A5, b};
    bus.sel = 1'b1;
    bus.we  = 1'b1;
    @(posedge clock);
    #1;
    bus.sel = 1'b0;
    bus.we  = 1'b0;
    bus.din = '0;
  endtask

  task automatic bus_read();
    @(negedge clock);
    bus.sel = 1'b1;
    bus.re  = 1'b1;
    @(posedge clock);
    #1;
    bus.sel = 1'b0;
    bus.re  = 1'b0;
  endtask

  task automatic wait_inhibit(output int n);
    n = 0;
    for (int t = 0; t < 10 * INH; t++) begin
      @(negedge clock);
      if (ps2_clk_oe) n++;
      else break;
    end
  endtask

  task automatic run_xfer(input logic [7:0] b, input bit ack, input bit poke, output logic [10:0] seen);
    int n;
    bus_write(b);
    m_byte = b;
    m_mode = 2;
    wait_inhibit(n);
    chk("inhibit_len", n, INH);
    chk("start_drive", ps2_dat_oe, 1);
    if (poke) bus_write(8'hF4);
    for (int k = 0; k < 11; k++) begin
      repeat (10) @(negedge clock);
      dev_clk = 1'b0;
      seen[k] = ps2_dat_line;
      if (k == 10) begin
        m_mode = 0;
        if (ack) dev_dat = 1'b0;
      end
      repeat (10) @(negedge clock);
      dev_clk = 1'b1;
    end
    for (int k = 0; k < 11; k++)
      chk($sformatf("frame_bit%0d", k), seen[k], exp_frame_bit(b, k));
    repeat (10) @(negedge clock);
    dev_dat = 1'b1;
    repeat (10) @(negedge clock);
    m_dout = model_status(b, 1'b1, !ack, 1'b0);
    m_mode = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [10:0] seen;
    int n;
    bus.sel = 1'b0;
    bus.we  = 1'b0;
    bus.re  = 1'b0;
    bus.din = '0;

    repeat (3) @(negedge clock);
    chk("reset_dout", bus.dout, 32'h0000_0000);
    chk("reset_clk_oe", ps2_clk_oe, 0);
    chk("reset_dat_oe", ps2_dat_oe, 0);
    chk("reset_busy", bus.busy, 0);
    clrn = 1'b1;
    m_dout = 32'h0;
    m_mode = 1;
    repeat (5) @(negedge clock);

    run_xfer(8'hED, 1'b1, 1'b0, seen);
    chk("ed_frame_literal", 32'(seen), 32'h0000_07DA);
    chk("ed_ack_dout", bus.dout, 32'h0000_ED02);
    repeat (5) @(negedge clock);

    run_xfer(8'hED, 1'b0, 1'b0, seen);
    chk("ed_nack_dout", bus.dout, 32'h0000_ED06);
    repeat (5) @(negedge clock);

    run_xfer(8'hED, 1'b1, 1'b1, seen);
    chk("busy_write_ignored", bus.dout, 32'h0000_ED02);
    m_mode = 0;
    bus_read();
    m_dout = model_status(8'hED, 1'b0, 1'b0, 1'b0);
    m_mode = 1;
    repeat (2) @(negedge clock);
    chk("read_clear_dout", bus.dout, 32'h0000_ED00);

    bus_write(8'h55);
    m_byte = 8'h55;
    m_mode = 2;
    wait_inhibit(n);
    chk("tmo_inhibit_len", n, INH);
    repeat (TMO - 1) @(negedge clock);
    chk("tmo_busy_before", bus.busy, 1);
    m_mode = 0;
    @(negedge clock);
    chk("tmo_busy_after", bus.busy, 0);
    chk("tmo_clk_oe", ps2_clk_oe, 0);
    chk("tmo_dat_oe", ps2_dat_oe, 0);
    chk("tmo_dout", bus.dout, 32'h0000_5508);
    m_dout = model_status(8'h55, 1'b0, 1'b0, 1'b1);
    m_mode = 1;
    repeat (5) @(negedge clock);

    bus_write(8'h00);
    m_byte = 8'h00;
    m_mode = 2;
    wait_inhibit(n);
    for (int k = 0; k < 3; k++) begin
      repeat (10) @(negedge clock);
      dev_clk = 1'b0;
      repeat (10) @(negedge clock);
      dev_clk = 1'b1;
    end
    repeat (10) @(negedge clock);
    dev_clk = 1'b0;
    repeat (6) @(negedge clock);
    chk("shift_dat_driven", ps2_dat_oe, 1);
    m_mode = 0;
    #2;
    clrn = 1'b0;
    #1;
    chk("async_clk_oe", ps2_clk_oe, 0);
    chk("async_dat_oe", ps2_dat_oe, 0);
    chk("async_dout", bus.dout, 32'h0000_0000);
    @(negedge clock);
    dev_clk = 1'b1;
    clrn = 1'b1;
    m_dout = 32'h0;
    m_mode = 1;
    repeat (5) @(negedge clock);
    m_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
